spy_capture: RTL and testbench
==============================

Name: spy_capture

Overview:
- Parametrised spy readout block for the debug interface. Successor to the fixed 16-bit spy mux with its single "ob from last cycle" latch.
- Samples NCH processor-side channels into a snapshot bank on each capture strobe, and keeps a DEPTH-entry history ring of one selectable trace channel.
- Serves SW-bit slices of live data, snapshot data, history entries or a status word to the debug bus through a registered read port.
- Sits between the datapath (ob, md, vma, ir, ...) and the debug-bus interface.

Parameters:
- NCH, 8: number of monitored channels.
- CW, 32: channel width in bits. Must be a multiple of SW.
- SW, 16: spy word (slice) width.
- DEPTH, 4: history ring depth. Must be a power of two, ≥2.
- Derived constants:
  - CHW = clog2(NCH)
  - SLW = max(1, clog2(CW/SW))
  - HW = clog2(DEPTH)

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ch_data  in  NCH*CW  channel k occupies bits [k*CW +: CW].
- capture  in  1  sample strobe (state_write-class timing).
- freeze  in  1  level; while high, all captures are ignored.
- clear_hist  in  1  synchronous clear of the history ring.
- trace_ch  in  CHW  channel pushed into the history ring on capture.
- spy_src  in  2  0 = live, 1 = snapshot, 2 = history, 3 = status.
- spy_ch  in  CHW  channel select (src 0/1).
- spy_slice  in  SLW  slice select; slice 0 = bits [SW-1:0].
- spy_hidx  in  HW  history age (src 2); 0 = newest.
- dbread  in  1  read request, sampled every cycle.
- spy_out  out  SW  registered read data.
- rd_valid  out  1  high the cycle spy_out carries requested data.

Behaviour:
- Reset (async): snapshot bank = 0, history storage = 0, wr_ptr = 0, count = 0, wrapped = 0, spy_out = all ones, rd_valid = 0.
- Capture, when capture=1 and freeze=0:
  - All NCH snapshot registers load ch_data.
  - hist[wr_ptr] loads channel trace_ch.
  - wr_ptr increments modulo DEPTH.
  - count saturates at DEPTH.
  - wrapped is set when wr_ptr wraps from DEPTH-1 to 0.
- freeze=1: snapshot, history, pointers and flags hold. Reads remain fully functional.
- clear_hist=1:
  - Next edge: wr_ptr = 0, count = 0, wrapped = 0. Snapshot bank is untouched.
  - Takes priority over a capture in the same cycle: the history push is dropped, but the snapshot bank still loads if freeze=0.
- Read path, every edge:
  - spy_out <= dbread ? mux : all ones.
  - rd_valid <= dbread.
  - Latency is exactly 1 cycle. Back-to-back reads are allowed, one per cycle.
- Mux selection:
  - src 0: slice spy_slice of live ch_data[spy_ch].
  - src 1: slice of snapshot[spy_ch].
  - src 2: slice of entry hist[(wr_ptr-1-spy_hidx) mod DEPTH].
  - src 3: status word, zero-extended to SW: {count[HW:0], wrapped, freeze}. freeze is bit 0.
- Out-of-range selects return all ones:
  - spy_ch ≥ NCH.
  - spy_slice ≥ CW/SW.
  - src 2 with spy_hidx ≥ count.
  - src 3 with spy_slice ≠ 0.
- Same-cycle capture and read: the read returns pre-capture snapshot/history contents. The status word also shows pre-capture count.
- Reset asserted mid-read: spy_out returns to all ones and rd_valid to 0 immediately, without waiting for a clock edge.

Decomposition:
- Shared package spy_pkg:
  - src encodings SPY_SRC_LIVE/SNAP/HIST/STAT.
  - all-ones idle constant.
  - clog2 function.
- One natural sub-module, spy_hist_ring: DEPTH x CW storage, wr_ptr, count, wrapped, and the age-indexed read port.
- The snapshot bank and slice mux remain in the top level.

Test Plan:
- Reset then read src0, ch2, slice1, with ch2 = 32'hDEADBEEF → next cycle spy_out = 16'hDEAD, rd_valid = 1. With dbread=0 → spy_out = 16'hFFFF, rd_valid = 0.
- Capture with ch0 = 32'h12345678, then change ch0 to 0; read src1, ch0, slice0 → 16'h5678, while src0 returns 16'h0000.
- trace_ch=3; five captures of ch3 = 1,2,3,4,5 with DEPTH=4:
  - hidx 0..3 → 5,4,3,2.
  - status → count=4, wrapped=1, i.e. 16'h0012 for HW=2.
- After two captures (count=2), read src2 hidx=2 → 16'hFFFF. Also spy_ch=NCH → 16'hFFFF.
- Assert freeze, pulse capture with new data → snapshot/history unchanged and status bit0 = 1. Simultaneously assert clear_hist and capture (freeze=0) → count=0 and snapshot updated.
- Assert reset mid-stream while dbread is high → spy_out = 16'hFFFF asynchronously. After release: count = 0, snapshot reads 0.

Source files
------------

// File: rtl/spy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spy_pkg
// Description : Shared definitions for the spy readout block. Holds the
//               read-source encodings, the idle (all-ones) read value and
//               a ceil-log2 helper used to size select ports.
// Revision    : 1.0 - initial parametrised spy readout
// ============================================================================
package spy_pkg;

   localparam logic [1:0] SPY_SRC_LIVE = 2'd0;
   localparam logic [1:0] SPY_SRC_SNAP = 2'd1;
   localparam logic [1:0] SPY_SRC_HIST = 2'd2;
   localparam logic [1:0] SPY_SRC_STAT = 2'd3;

   // Idle / out-of-range read value; sliced down to the spy word width.
   localparam logic [63:0] SPY_IDLE = '1;

   // Number of bits needed to index v items (0 for v <= 1).
   function automatic int spy_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spy_hist_ring.sv
`default_nettype none
// ============================================================================
// Module      : spy_hist_ring
// Description : DEPTH-entry history ring of CW-bit trace samples with a
//               saturating fill count, sticky wrap flag and an age-indexed
//               combinational read port (age 0 = newest entry).
// Ports       : clk, reset (async, active-high)
//               push     - write din at wr_ptr and advance
//               clear    - reset wr_ptr/count/wrapped (storage untouched)
//               din      - sample to store
//               hidx     - read age
//               rd_data  - entry at the requested age
//               rd_ok    - requested age holds a valid entry (hidx < count)
//               count    - number of valid entries, saturates at DEPTH
//               wrapped  - set once wr_ptr has wrapped DEPTH-1 -> 0
// Revision    : 1.0 - initial parametrised spy readout
// ============================================================================
module spy_hist_ring
   import spy_pkg::*;
#(
   parameter int CW    = 32,
   parameter int DEPTH = 4,
   parameter int HW    = spy_clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          clear,
   input  logic [CW-1:0] din,
   input  logic [HW-1:0] hidx,
   output logic [CW-1:0] rd_data,
   output logic          rd_ok,
   output logic [HW:0]   count,
   output logic          wrapped
);

   logic [CW-1:0] r_mem [DEPTH];
   logic [HW-1:0] r_wr_ptr;
   logic [HW:0]   r_count;
   logic          r_wrapped;
   logic [HW-1:0] w_rd_idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr  <= '0;
         r_count   <= '0;
         r_wrapped <= 1'b0;
      end else if (clear) begin
         r_wr_ptr  <= '0;
         r_count   <= '0;
         r_wrapped <= 1'b0;
      end else if (push) begin
         r_mem[r_wr_ptr] <= din;
         // DEPTH is a power of two, so the natural HW-bit rollover is mod DEPTH.
         r_wr_ptr <= r_wr_ptr + HW'(1);
         if (r_count != (HW+1)'(DEPTH)) r_count <= r_count + (HW+1)'(1);
         if (r_wr_ptr == HW'(DEPTH - 1)) r_wrapped <= 1'b1;
      end
   end

   // Newest entry sits just behind the write pointer.
   assign w_rd_idx = r_wr_ptr - HW'(1) - hidx;
   assign rd_data  = r_mem[w_rd_idx];
   assign rd_ok    = ({1'b0, hidx} < r_count);
   assign count    = r_count;
   assign wrapped  = r_wrapped;

endmodule
`default_nettype wire

// File: rtl/spy_capture.sv
`default_nettype none
// ============================================================================
// Module      : spy_capture
// Description : Parametrised spy readout. Snapshots NCH channels on each
//               capture strobe, keeps a history ring of one trace channel,
//               and serves SW-bit slices of live, snapshot, history or
//               status data through a one-cycle registered read port.
// Ports       : clk, reset (async, active-high)
//               ch_data    - NCH channels, channel k at [k*CW +: CW]
//               capture    - sample strobe
//               freeze     - level; holds all capture state while high
//               clear_hist - clears history pointers/count/wrap flag
//               trace_ch   - channel pushed into history on capture
//               spy_src    - 0 live, 1 snapshot, 2 history, 3 status
//               spy_ch     - channel select for live/snapshot
//               spy_slice  - SW-bit slice select, slice 0 = LSBs
//               spy_hidx   - history age, 0 = newest
//               dbread     - read request
//               spy_out    - registered read data (all ones when idle)
//               rd_valid   - spy_out carries requested data
// Revision    : 1.0 - initial parametrised spy readout
// ============================================================================
module spy_capture
   import spy_pkg::*;
#(
   parameter int NCH   = 8,
   parameter int CW    = 32,
   parameter int SW    = 16,
   parameter int DEPTH = 4,
   parameter int CHW   = spy_clog2(NCH),
   parameter int SLW   = (spy_clog2(CW / SW) > 1) ? spy_clog2(CW / SW) : 1,
   parameter int HW    = spy_clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH*CW-1:0] ch_data,
   input  logic              capture,
   input  logic              freeze,
   input  logic              clear_hist,
   input  logic [CHW-1:0]    trace_ch,
   input  logic [1:0]        spy_src,
   input  logic [CHW-1:0]    spy_ch,
   input  logic [SLW-1:0]    spy_slice,
   input  logic [HW-1:0]     spy_hidx,
   input  logic              dbread,
   output logic [SW-1:0]     spy_out,
   output logic              rd_valid
);

   localparam int NSL = CW / SW;
   localparam logic [SW-1:0] C_IDLE = SPY_IDLE[SW-1:0];

   logic [CW-1:0] r_snap [NCH];

   logic          w_cap;
   logic          w_push;
   logic          w_clear;
   logic [CW-1:0] w_trace;
   logic [CW-1:0] w_hist;
   logic          w_hist_ok;
   logic [HW:0]   w_count;
   logic          w_wrapped;

   logic [CW-1:0] w_live;
   logic [CW-1:0] w_snap;
   logic          w_ch_ok;
   logic [CW-1:0] w_word;
   logic [SW-1:0] w_slice;
   logic          w_slice_ok;
   logic [SW-1:0] w_stat;
   logic [SW-1:0] w_mux;

   // freeze gates every state change, including the history clear.
   assign w_cap   = capture & ~freeze;
   assign w_clear = clear_hist & ~freeze;
   assign w_push  = w_cap & ~clear_hist;

   // ---------------------------------------------------------------- snapshot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NCH; k++) r_snap[k] <= '0;
      end else if (w_cap) begin
         for (int k = 0; k < NCH; k++) r_snap[k] <= ch_data[k*CW +: CW];
      end
   end

   // ----------------------------------------------------------------- history
   always_comb begin
      w_trace = '0;
      for (int k = 0; k < NCH; k++)
         if (int'(trace_ch) == k) w_trace = ch_data[k*CW +: CW];
   end

   spy_hist_ring #(
      .CW    (CW),
      .DEPTH (DEPTH),
      .HW    (HW)
   ) u_hist (
      .clk     (clk),
      .reset   (reset),
      .push    (w_push),
      .clear   (w_clear),
      .din     (w_trace),
      .hidx    (spy_hidx),
      .rd_data (w_hist),
      .rd_ok   (w_hist_ok),
      .count   (w_count),
      .wrapped (w_wrapped)
   );

   // --------------------------------------------------------------- read mux
   always_comb begin
      w_ch_ok = 1'b0;
      w_live  = '0;
      w_snap  = '0;
      for (int k = 0; k < NCH; k++) begin
         if (int'(spy_ch) == k) begin
            w_ch_ok = 1'b1;
            w_live  = ch_data[k*CW +: CW];
            w_snap  = r_snap[k];
         end
      end

      case (spy_src)
         SPY_SRC_LIVE: w_word = w_live;
         SPY_SRC_SNAP: w_word = w_snap;
         default:      w_word = w_hist;
      endcase

      w_slice_ok = 1'b0;
      w_slice    = '0;
      for (int s = 0; s < NSL; s++) begin
         if (int'(spy_slice) == s) begin
            w_slice_ok = 1'b1;
            w_slice    = w_word[s*SW +: SW];
         end
      end

      w_stat = '0;
      w_stat[HW+2:0] = {w_count, w_wrapped, freeze};

      case (spy_src)
         SPY_SRC_LIVE,
         SPY_SRC_SNAP: w_mux = (w_ch_ok && w_slice_ok) ? w_slice : C_IDLE;
         SPY_SRC_HIST: w_mux = (w_hist_ok && w_slice_ok) ? w_slice : C_IDLE;
         default:      w_mux = (spy_slice == '0) ? w_stat : C_IDLE;
      endcase
   end

   // -------------------------------------------------------------- read port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spy_out  <= C_IDLE;
         rd_valid <= 1'b0;
      end else begin
         spy_out  <= dbread ? w_mux : C_IDLE;
         rd_valid <= dbread;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spy_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_spy_capture
// Description : Directed self-checking bench for spy_capture (NCH=6 so an
//               out-of-range channel select is reachable, DEPTH=4).
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_spy_capture;

   localparam int NCH   = 6;
   localparam int CW    = 32;
   localparam int SW    = 16;
   localparam int DEPTH = 4;
   localparam int CHW   = 3;
   localparam int SLW   = 1;
   localparam int HW    = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH*CW-1:0] ch_data;
   logic              capture;
   logic              freeze;
   logic              clear_hist;
   logic [CHW-1:0]    trace_ch;
   logic [1:0]        spy_src;
   logic [CHW-1:0]    spy_ch;
   logic [SLW-1:0]    spy_slice;
   logic [HW-1:0]     spy_hidx;
   logic              dbread;
   logic [SW-1:0]     spy_out;
   logic              rd_valid;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spy_capture #(
      .NCH(NCH), .CW(CW), .SW(SW), .DEPTH(DEPTH),
      .CHW(CHW), .SLW(SLW), .HW(HW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ch_data    (ch_data),
      .capture    (capture),
      .freeze     (freeze),
      .clear_hist (clear_hist),
      .trace_ch   (trace_ch),
      .spy_src    (spy_src),
      .spy_ch     (spy_ch),
      .spy_slice  (spy_slice),
      .spy_hidx   (spy_hidx),
      .dbread     (dbread),
      .spy_out    (spy_out),
      .rd_valid   (rd_valid)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_ch(input int k, input logic [31:0] v);
      ch_data[k*CW +: CW] = v;
   endtask

   // Called at posedge+1; issues one read (optionally with a same-cycle
   // capture) and checks data and valid one cycle later.
   task automatic rd(input string tag, input logic [1:0] src, input logic [2:0] ch,
                     input logic slc, input logic [1:0] hidx, input logic cap,
                     input logic [15:0] exp);
      spy_src   = src;
      spy_ch    = ch;
      spy_slice = slc;
      spy_hidx  = hidx;
      capture   = cap;
      dbread    = 1'b1;
      @(posedge clk); #1;
      dbread  = 1'b0;
      capture = 1'b0;
      chk(tag, {16'h0, spy_out}, {16'h0, exp});
      chk({tag, "_vld"}, {31'h0, rd_valid}, 32'h1);
   endtask

   task automatic cap_pulse();
      capture = 1'b1;
      @(posedge clk); #1;
      capture = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ch_data = '0; capture = 1'b0; freeze = 1'b0;
      clear_hist = 1'b0; trace_ch = '0; spy_src = '0; spy_ch = '0;
      spy_slice = '0; spy_hidx = '0; dbread = 1'b0;
      set_ch(2, 32'hDEADBEEF);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", {16'h0, spy_out}, 32'h0000FFFF);
      chk("rst_vld", {31'h0, rd_valid}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Live read and idle read
      rd("live_ch2_s1", 2'd0, 3'd2, 1'b1, 2'd0, 1'b0, 16'hDEAD);
      rd("live_ch2_s0", 2'd0, 3'd2, 1'b0, 2'd0, 1'b0, 16'hBEEF);
      @(posedge clk); #1;
      chk("idle_out", {16'h0, spy_out}, 32'h0000FFFF);
      chk("idle_vld", {31'h0, rd_valid}, 32'h0);
      rd("rst_snap", 2'd1, 3'd2, 1'b1, 2'd0, 1'b0, 16'h0000);

      // Snapshot vs live (trace_ch=0 pushes ch0 too)
      set_ch(0, 32'h12345678);
      cap_pulse();
      set_ch(0, 32'h0);
      rd("snap_s0", 2'd1, 3'd0, 1'b0, 2'd0, 1'b0, 16'h5678);
      rd("snap_s1", 2'd1, 3'd0, 1'b1, 2'd0, 1'b0, 16'h1234);
      rd("live_ch0", 2'd0, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000);
      rd("stat_1", 2'd3, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0004);

      // History wrap: 5 more pushes of ch3
      trace_ch = 3'd3;
      for (int v = 1; v <= 5; v++) begin
         set_ch(3, 32'(v));
         cap_pulse();
      end
      rd("hist_0", 2'd2, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0005);
      rd("hist_1", 2'd2, 3'd0, 1'b0, 2'd1, 1'b0, 16'h0004);
      rd("hist_2", 2'd2, 3'd0, 1'b0, 2'd2, 1'b0, 16'h0003);
      rd("hist_3", 2'd2, 3'd0, 1'b0, 2'd3, 1'b0, 16'h0002);
      rd("stat_wrap", 2'd3, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0012);
      rd("stat_s1", 2'd3, 3'd0, 1'b1, 2'd0, 1'b0, 16'hFFFF);

      // Clear, two pushes, out-of-range age and channel
      clear_hist = 1'b1;
      @(posedge clk); #1;
      clear_hist = 1'b0;
      rd("stat_clr", 2'd3, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000);
      set_ch(3, 32'h00070007); cap_pulse();
      set_ch(3, 32'h00080008); cap_pulse();
      rd("h2_0", 2'd2, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0008);
      rd("h2_1", 2'd2, 3'd0, 1'b1, 2'd1, 1'b0, 16'h0007);
      rd("h2_oor", 2'd2, 3'd0, 1'b0, 2'd2, 1'b0, 16'hFFFF);
      rd("ch_oor", 2'd0, 3'd6, 1'b0, 2'd0, 1'b0, 16'hFFFF);
      rd("stat_2", 2'd3, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0008);

      // Freeze blocks capture; reads still work
      freeze = 1'b1;
      set_ch(0, 32'hAAAA5555);
      set_ch(3, 32'h00000099);
      cap_pulse();
      rd("frz_snap", 2'd1, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000);
      rd("frz_live", 2'd0, 3'd0, 1'b0, 2'd0, 1'b0, 16'h5555);
      rd("frz_hist", 2'd2, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0008);
      rd("frz_stat", 2'd3, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0009);
      freeze = 1'b0;

      // clear_hist + capture: history cleared, snapshot loads
      clear_hist = 1'b1;
      cap_pulse();
      clear_hist = 1'b0;
      rd("cc_stat", 2'd3, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000);
      rd("cc_snap0", 2'd1, 3'd0, 1'b0, 2'd0, 1'b0, 16'h5555);
      rd("cc_snap1", 2'd1, 3'd0, 1'b1, 2'd0, 1'b0, 16'hAAAA);
      rd("cc_hist", 2'd2, 3'd0, 1'b0, 2'd0, 1'b0, 16'hFFFF);

      // Same-cycle capture and read sees pre-capture state
      set_ch(0, 32'h11112222);
      rd("sc_stat", 2'd3, 3'd0, 1'b0, 2'd0, 1'b1, 16'h0000);
      rd("sc_stat2", 2'd3, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0004);
      set_ch(0, 32'h33334444);
      rd("sc_snap", 2'd1, 3'd0, 1'b0, 2'd0, 1'b1, 16'h2222);
      rd("sc_snap2", 2'd1, 3'd0, 1'b0, 2'd0, 1'b0, 16'h4444);

      // Asynchronous reset mid-read
      spy_src = 2'd0; spy_ch = 3'd2; spy_slice = 1'b1; dbread = 1'b1;
      @(posedge clk); #1;
      chk("pre_rst", {16'h0, spy_out}, 32'h0000DEAD);
      #2 reset = 1'b1;
      #1;
      chk("async_out", {16'h0, spy_out}, 32'h0000FFFF);
      chk("async_vld", {31'h0, rd_valid}, 32'h0);
      @(posedge clk); #1;
      reset  = 1'b0;
      dbread = 1'b0;
      rd("post_stat", 2'd3, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000);
      rd("post_snap", 2'd1, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
